// File: rtl/arcade_input_mapper.sv
`default_nettype none
// ============================================================================
// Module   : arcade_input_mapper
// Purpose  : Turns PS/2 key events into held key state and merges them with
//            up to four HPS joysticks. Applies 0/90/180/270 degree control
//            rotation and drives registered per-player CSJUDLR vectors with
//            stretched coin pulses, plus a service key.
// Ports    : clk_sys         - system clock (only clock)
//            reset_n         - asynchronous active-low reset
//            ps2_key[10:0]   - {toggle, pressed, extended, scancode}
//            joy_in          - 16 bits per player: [0]R [1]L [2]D [3]U
//                              [4]fire [5]start1 [6]start2 [7]autofire
//            joy_merge       - every player sees the OR of all joysticks
//            rotate[1:0]     - 0/90/180/270 degree control rotation
//            coin_from_start - start buttons also act as coin sources
//            p_csjudlr       - per player {coin,start,fire,up,down,left,right}
//            service         - service/test key (T)
// Config   : define ARCADE_INPUT_AUTOFIRE_EN to enable the autofire phase
//            counter; otherwise joystick bit [7] is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module arcade_input_mapper #(
    parameter int          PLAYERS           = 2,
    parameter logic [15:0] COIN_PULSE_CYCLES = 16'd60000,
    parameter logic [19:0] AUTOFIRE_DIV      = 20'd300000
) (
    input  logic                   clk_sys,
    input  logic                   reset_n,
    input  logic [10:0]            ps2_key,
    input  logic [PLAYERS*16-1:0]  joy_in,
    input  logic                   joy_merge,
    input  logic [1:0]             rotate,
    input  logic                   coin_from_start,
    output logic [PLAYERS*7-1:0]   p_csjudlr,
    output logic                   service
);

    // Held-key slots, one per physical key so that two keys sharing a
    // function (space/ctrl, F1/1, F2/2) release independently.
    localparam int c_NKEYS   = 18;
    localparam int c_K_UP    = 0;
    localparam int c_K_DOWN  = 1;
    localparam int c_K_LEFT  = 2;
    localparam int c_K_RIGHT = 3;
    localparam int c_K_SPACE = 4;
    localparam int c_K_CTRL  = 5;
    localparam int c_K_F1    = 6;
    localparam int c_K_1     = 7;
    localparam int c_K_F2    = 8;
    localparam int c_K_2     = 9;
    localparam int c_K_5     = 10;
    localparam int c_K_R     = 11;
    localparam int c_K_F     = 12;
    localparam int c_K_D     = 13;
    localparam int c_K_G     = 14;
    localparam int c_K_A     = 15;
    localparam int c_K_6     = 16;
    localparam int c_K_T     = 17;

    // Keys that feed player 2 (including start2, which routes to player 2)
    localparam logic [c_NKEYS-1:0] c_P2_KEYS =
        (18'd1 << c_K_F2) | (18'd1 << c_K_2) | (18'd1 << c_K_R) |
        (18'd1 << c_K_F)  | (18'd1 << c_K_D) | (18'd1 << c_K_G) |
        (18'd1 << c_K_A)  | (18'd1 << c_K_6);
    localparam logic [c_NKEYS-1:0] c_KEY_MASK =
        (PLAYERS >= 2) ? {c_NKEYS{1'b1}} : ~c_P2_KEYS;

    logic               r_primed;
    logic               r_old_tog;
    logic [c_NKEYS-1:0] r_held;
    logic [c_NKEYS-1:0] w_hit;
    logic [c_NKEYS-1:0] w_upd;
    logic               w_event;
    logic [15:0]        w_joy_or;
    logic               r_service;
    logic               w_af_phase;

    // ------------------------------------------------------------------
    // Scancode decode. Arrows ignore the extended flag; everything else
    // must be a non-extended code.
    // ------------------------------------------------------------------
    always_comb begin
        w_hit = '0;
        case (ps2_key[7:0])
            8'h75:   w_hit[c_K_UP]    = 1'b1;
            8'h72:   w_hit[c_K_DOWN]  = 1'b1;
            8'h6B:   w_hit[c_K_LEFT]  = 1'b1;
            8'h74:   w_hit[c_K_RIGHT] = 1'b1;
            8'h29:   w_hit[c_K_SPACE] = ~ps2_key[8];
            8'h14:   w_hit[c_K_CTRL]  = ~ps2_key[8];
            8'h05:   w_hit[c_K_F1]    = ~ps2_key[8];
            8'h16:   w_hit[c_K_1]     = ~ps2_key[8];
            8'h06:   w_hit[c_K_F2]    = ~ps2_key[8];
            8'h1E:   w_hit[c_K_2]     = ~ps2_key[8];
            8'h2E:   w_hit[c_K_5]     = ~ps2_key[8];
            8'h2D:   w_hit[c_K_R]     = ~ps2_key[8];
            8'h2B:   w_hit[c_K_F]     = ~ps2_key[8];
            8'h23:   w_hit[c_K_D]     = ~ps2_key[8];
            8'h34:   w_hit[c_K_G]     = ~ps2_key[8];
            8'h1C:   w_hit[c_K_A]     = ~ps2_key[8];
            8'h36:   w_hit[c_K_6]     = ~ps2_key[8];
            8'h2C:   w_hit[c_K_T]     = ~ps2_key[8];
            default: w_hit = '0;
        endcase
    end

    // The first cycle after reset only captures the toggle level, so a
    // toggle already high at release is not mistaken for an event.
    assign w_event = r_primed & (r_old_tog ^ ps2_key[10]);
    assign w_upd   = w_event ? (w_hit & c_KEY_MASK) : '0;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_primed  <= 1'b0;
            r_old_tog <= 1'b0;
            r_held    <= '0;
            r_service <= 1'b0;
        end else begin
            r_primed  <= 1'b1;
            r_old_tog <= ps2_key[10];
            r_held    <= (r_held & ~w_upd) | (w_upd & {c_NKEYS{ps2_key[9]}});
            r_service <= r_held[c_K_T];
        end
    end

    assign service = r_service;

    always_comb begin
        w_joy_or = '0;
        for (int i = 0; i < PLAYERS; i++) begin
            w_joy_or = w_joy_or | joy_in[i*16 +: 16];
        end
    end

`ifdef ARCADE_INPUT_AUTOFIRE_EN
    logic [19:0] r_af_cnt;
    logic        r_af_phase;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_af_cnt   <= '0;
            r_af_phase <= 1'b0;
        end else if (r_af_cnt >= AUTOFIRE_DIV - 20'd1) begin
            r_af_cnt   <= '0;
            r_af_phase <= ~r_af_phase;
        end else begin
            r_af_cnt   <= r_af_cnt + 20'd1;
        end
    end

    assign w_af_phase = r_af_phase;
`else
    assign w_af_phase = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Per-player merge, rotation and coin stretching
    // ------------------------------------------------------------------
    genvar p;
    generate
        for (p = 0; p < PLAYERS; p = p + 1) begin : g_player
            logic [7:0]  w_joy;
            logic [3:0]  w_kb_dir;   // {up,down,left,right}
            logic [3:0]  w_raw;
            logic [3:0]  w_dir;
            logic        w_start;
            logic        w_kb_fire;
            logic        w_fire;
            logic        w_coin_key;
            logic        w_src;
            logic        w_rise;
            logic [15:0] w_coin_next;
            logic [15:0] r_coin_cnt;
            logic        r_src_d;
            logic [6:0]  r_out;
            logic        w_unused_joy;

            assign w_joy = joy_merge ? w_joy_or[7:0] : joy_in[p*16 +: 8];

            if (p == 0) begin : g_kb_p1
                assign w_kb_dir   = {r_held[c_K_UP], r_held[c_K_DOWN],
                                     r_held[c_K_LEFT], r_held[c_K_RIGHT]};
                assign w_kb_fire  = r_held[c_K_SPACE] | r_held[c_K_CTRL];
                assign w_start    = r_held[c_K_F1] | r_held[c_K_1] | w_joy[5];
                assign w_coin_key = r_held[c_K_5];
            end else if (p == 1) begin : g_kb_p2
                assign w_kb_dir   = {r_held[c_K_R], r_held[c_K_F],
                                     r_held[c_K_D], r_held[c_K_G]};
                assign w_kb_fire  = r_held[c_K_A];
                // Start2 from any joystick, not just this player's
                assign w_start    = r_held[c_K_F2] | r_held[c_K_2] | w_joy_or[6];
                assign w_coin_key = r_held[c_K_6];
            end else begin : g_kb_none
                assign w_kb_dir   = 4'b0000;
                assign w_kb_fire  = 1'b0;
                assign w_start    = joy_in[p*16 + 5];
                assign w_coin_key = 1'b0;
            end

            // Joystick [3:0] is already {up,down,left,right}
            assign w_raw = w_joy[3:0] | w_kb_dir;

            always_comb begin
                case (rotate)
                    2'd0:    w_dir = w_raw;
                    2'd1:    w_dir = {w_raw[1], w_raw[0], w_raw[2], w_raw[3]};
                    2'd2:    w_dir = {w_raw[2], w_raw[3], w_raw[0], w_raw[1]};
                    default: w_dir = {w_raw[0], w_raw[1], w_raw[3], w_raw[2]};
                endcase
            end

            assign w_fire = w_joy[4] | w_kb_fire | (w_joy[7] & w_af_phase);

            // Only a rising source (re)loads the counter, so holding the
            // coin key cannot extend the pulse.
            assign w_src       = w_coin_key | (coin_from_start & w_start);
            assign w_rise      = w_src & ~r_src_d;
            assign w_coin_next = w_rise ? COIN_PULSE_CYCLES :
                                 (r_coin_cnt != 16'd0) ? r_coin_cnt - 16'd1 : 16'd0;

            always_ff @(posedge clk_sys or negedge reset_n) begin
                if (!reset_n) begin
                    r_src_d    <= 1'b0;
                    r_coin_cnt <= '0;
                    r_out      <= '0;
                end else begin
                    r_src_d    <= w_src;
                    r_coin_cnt <= w_coin_next;
                    r_out      <= {(w_coin_next != 16'd0), w_start, w_fire, w_dir};
                end
            end

            assign p_csjudlr[p*7 +: 7] = r_out;
            assign w_unused_joy        = &{1'b0, w_joy};
        end
    endgenerate

    logic w_unused_misc;
    assign w_unused_misc = &{1'b0, joy_in, w_joy_or, r_held, AUTOFIRE_DIV};

endmodule
`default_nettype wire

// File: doc/arcade_input_mapper.md
# arcade_input_mapper

Parametrised successor to the per-core keyboard/joystick glue in the arcade top level. Decodes PS/2 key events into held key state, merges them with up to four HPS joysticks, applies 0/90/180/270° control rotation, and produces registered per-player CSJUDLR vectors with stretched coin pulses and a service button. Sits between `hps_io` and the game core's input port.

## Interface
Parameters:
- `PLAYERS`, 2, number of player vectors produced, range 1–4.
- `COIN_PULSE_CYCLES`, 16'd60000, coin output high time in `clk_sys` cycles, range 1–65535.
- `AUTOFIRE_DIV`, 20'd300000, autofire half-period in cycles, range ≥1; used only with `AUTOFIRE_EN`.

Ports (clock and reset first):
- `clk_sys`  in  1  system clock; the block's only clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ps2_key`  in  11  `[10]` event toggle, `[9]` pressed, `[8]` extended, `[7:0]` scancode.
- `joy_in`  in  `PLAYERS*16`  joystick bits per player. Bit `[0]` right, `[1]` left, `[2]` down, `[3]` up, `[4]` fire, `[5]` start1, `[6]` start2, `[7]` autofire.
- `joy_merge`  in  1  1: every player sees the OR of all joysticks.
- `rotate`  in  2  0 = 0°, 1 = 90°, 2 = 180°, 3 = 270°.
- `coin_from_start`  in  1  1: start1/start2 also act as that player's coin source.
- `p_csjudlr`  out  `PLAYERS*7`  per player `{coin,start,fire,up,down,left,right}`; player `n` is at `[7n+6:7n]`.
- `service`  out  1  service/test key.

## Operation
- **Event detect.** Register `ps2_key[10]` into `old_tog`. An event occurs when `old_tog != ps2_key[10]`. The first cycle after reset release only primes `old_tog`; no decode happens in that cycle.
- **Key map.** Arrows (0x75/72/6B/74) match with `[8]` don't-care. All other codes require `[8]=0`. On an event, set the matching held bit to `[9]`.
  - Player 1: arrows; fire = space 0x29 or ctrl 0x14; start1 = F1 0x05 or "1" 0x16; start2 = F2 0x06 or "2" 0x1E; coin = "5" 0x2E.
  - Player 2: R 0x2D, F 0x2B, D 0x23, G 0x34 (up/down/left/right); fire = A 0x1C; coin = "6" 0x36.
  - Service: T 0x2C.
  - Players 3–4 have no keys. Keys for players ≥ `PLAYERS` are ignored.
- **Start routing.** Player 1's start bit = start1 (keyboard or joystick) of player 1. Player 2's start bit = start2 (keyboard or any joystick's `[6]`). Players 3–4: start bit = own `[5]`.
- **Raw direction.** Joystick bits (merged or own) OR keyboard bits.
- **Rotation** (U/D/L/R outputs ← raw):
  - 0: U/D/L/R.
  - 1: L/R/D/U.
  - 2: D/U/R/L.
  - 3: R/L/U/D.
- **Coin.** Coin source = coin key OR (`coin_from_start` & that player's start). A rising edge of the source loads a 16-bit counter with `COIN_PULSE_CYCLES`. The output is high while the counter is non-zero. A rising edge while the counter is active reloads it. A held source does not extend the pulse.
- All outputs are registered.

## Timing
- **Reset.** All held keys, counters, `old_tog`, the prime flag, `p_csjudlr` and `service` are 0.
- **Keyboard latency.** A toggle change sampled at edge k updates the held bit at edge k; the output reflects it at edge k+1.
- **Joystick, `rotate`, `joy_merge` latency.** 1 cycle.
- **Coin latency.** Output rises 1 cycle after the source rises and stays high for exactly `COIN_PULSE_CYCLES` cycles.
- **Event rate.** At most one PS/2 event per cycle. Press and release of the same key on consecutive events are both applied in order.
- **Reset mid-pulse.** Coin output is cleared immediately (asynchronously).
- **Rotate change while a direction is held.** The new mapping applies on the next cycle, with no glitch cycle.

## Configuration
- Macro `ARCADE_INPUT_AUTOFIRE_EN`.
- **Defined:** a free-running counter toggles a phase bit every `AUTOFIRE_DIV` cycles. Each player's fire = normal fire OR (`[7]` & phase). The phase counter is reset to 0.
- **Undefined:** joystick bit `[7]` is ignored; no counter is synthesised.

## Test plan
- **Event decode and latency.** Reset, then toggle `ps2_key` = {1,1,0,0x29}. Player 1 fire = 1 two edges later. Then send {0,0,0,0x29}: fire = 0.
- **Rotation.** `joy_in[3]` = 1 (up) with rotate = 0,1,2,3. Player 1 output is up, right, down, left respectively, each 1 cycle after `rotate` changes.
- **Coin pulse.** `COIN_PULSE_CYCLES` = 5; hold key "5" for 20 cycles. Coin is high for exactly 5 cycles. A re-press at cycle 3 of the pulse gives 5 more cycles from the reload.
- **Prime guard.** Hold `ps2_key[10]` = 1 with code 0x16 pressed through reset release. Start stays 0. With `coin_from_start` = 1, no coin pulse occurs.
- **Merge and player count.** `PLAYERS` = 1, `joy_merge` = 1, `joy_in` player-1 `[0]` = 1. Right = 1. A press of R (0x2D) has no effect.
- **Autofire (macro defined).** `AUTOFIRE_DIV` = 4 with `[7]` held. Fire toggles every 4 cycles. With the macro undefined, fire stays 0.
